// File: rtl/ssm_master_arb_pkg.sv
// Shared types and limits for the SSM master-interface arbiter.
package ssm_master_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RD      = 2'd0,
    WR      = 2'd1,
    ILLEGAL = 2'd2
  } op_t;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

endpackage

// File: rtl/ssm_rr_arbiter.sv
// Combinational round-robin pick: first pending requester at or after ptr, wrapping.
module ssm_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] k;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    k       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      k = sum[IDX_W-1:0];
      if (!gnt_vld && pending[k]) begin
        gnt_vld    = 1'b1;
        gnt_idx    = k;
        gnt_oh[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ssm_master_arbiter.sv
// Round-robin sharing of the a2rtap master interface between NUM_REQ requesters.
// Optional watchdog on unanswered transactions: define SSM_MASTER_ARB_TIMEOUT_EN.
module ssm_master_arbiter
  import ssm_master_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*DATA_W-1:0] req_write_data,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         req_read_data,
  output logic                      req_error,
  output logic [ADDR_W-1:0]         a2rtap_master_ifc_address,
  output logic [DATA_W-1:0]         a2rtap_master_ifc_write_data,
  output logic                      a2rtap_master_ifc_read,
  output logic                      a2rtap_master_ifc_write,
  input  logic [DATA_W-1:0]         a2rtap_master_ifc_read_data,
  input  logic                      a2rtap_master_ifc_ready,
  input  logic                      a2rtap_master_ifc_error
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("ssm_master_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 2");
  end

  state_t               state, next_state;
  op_t                  op, gnt_op;
  logic [NUM_REQ-1:0]   pending, gnt_oh, gnt_oh_r;
  logic [IDX_W-1:0]     gnt_idx, grant, ptr;
  logic                 gnt_vld, bus_timeout;

  assign pending = req_read | req_write;

  ssm_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .pending (pending),
    .ptr     (ptr),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    if (req_read[gnt_idx] && req_write[gnt_idx]) gnt_op = ILLEGAL;
    else if (req_read[gnt_idx])                  gnt_op = RD;
    else                                         gnt_op = WR;
  end

`ifdef SSM_MASTER_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] cnt;

  // Counter is held at zero outside BUS, so it starts fresh on every entry.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)                       cnt <= '0;
    else if (state != BUS)             cnt <= '0;
    else if (!a2rtap_master_ifc_ready) cnt <= cnt + 1'b1;
  end

  assign bus_timeout = (state == BUS) && !a2rtap_master_ifc_ready &&
                       (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign bus_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (gnt_vld) next_state = (gnt_op == ILLEGAL) ? DONE : BUS;
      BUS:     if (a2rtap_master_ifc_ready || bus_timeout) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // req_done is loaded on the transition into DONE, so it is high exactly for the DONE cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      req_done                     <= '0;
      req_read_data                <= '0;
      req_error                    <= 1'b0;
      a2rtap_master_ifc_address    <= '0;
      a2rtap_master_ifc_write_data <= '0;
      a2rtap_master_ifc_read       <= 1'b0;
      a2rtap_master_ifc_write      <= 1'b0;
      grant                        <= '0;
      gnt_oh_r                     <= '0;
      ptr                          <= '0;
      op                           <= RD;
    end else begin
      req_done <= '0;
      case (state)
        IDLE: if (gnt_vld) begin
          grant                        <= gnt_idx;
          gnt_oh_r                     <= gnt_oh;
          op                           <= gnt_op;
          a2rtap_master_ifc_address    <= req_address[int'(gnt_idx)*ADDR_W +: ADDR_W];
          a2rtap_master_ifc_write_data <= req_write_data[int'(gnt_idx)*DATA_W +: DATA_W];
          a2rtap_master_ifc_read       <= (gnt_op == RD);
          a2rtap_master_ifc_write      <= (gnt_op == WR);
          if (gnt_op == ILLEGAL) begin
            req_read_data <= '0;
            req_error     <= 1'b1;
            req_done      <= gnt_oh;
          end
        end
        BUS: if (a2rtap_master_ifc_ready) begin
          a2rtap_master_ifc_read  <= 1'b0;
          a2rtap_master_ifc_write <= 1'b0;
          req_read_data           <= (op == RD) ? a2rtap_master_ifc_read_data : '0;
          req_error               <= a2rtap_master_ifc_error;
          req_done                <= gnt_oh_r;
        end else if (bus_timeout) begin
          a2rtap_master_ifc_read  <= 1'b0;
          a2rtap_master_ifc_write <= 1'b0;
          req_read_data           <= '0;
          req_error               <= 1'b1;
          req_done                <= gnt_oh_r;
        end
        DONE: ptr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ssm_master_arbiter.sv
// Randomized self-checking bench for ssm_master_arbiter against a transaction-level model.
module tb_ssm_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;
`ifdef SSM_MASTER_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_;
  logic [N*AW-1:0] req_address;
  logic [N*DW-1:0] req_write_data;
  logic [N-1:0]    req_read, req_write, req_done;
  logic [DW-1:0]   req_read_data;
  logic            req_error;
  logic [AW-1:0]   a_addr;
  logic [DW-1:0]   a_wdata, a_rdata;
  logic            a_read, a_write, a_ready, a_error;

  ssm_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk                          (clk),
    .reset_                       (reset_),
    .req_address                  (req_address),
    .req_write_data               (req_write_data),
    .req_read                     (req_read),
    .req_write                    (req_write),
    .req_done                     (req_done),
    .req_read_data                (req_read_data),
    .req_error                    (req_error),
    .a2rtap_master_ifc_address    (a_addr),
    .a2rtap_master_ifc_write_data (a_wdata),
    .a2rtap_master_ifc_read       (a_read),
    .a2rtap_master_ifc_write      (a_write),
    .a2rtap_master_ifc_read_data  (a_rdata),
    .a2rtap_master_ifc_ready      (a_ready),
    .a2rtap_master_ifc_error      (a_error)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: per-requester request state plus the round-robin pointer.
  bit          m_rd [N];
  bit          m_wr [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  int          ptr = 0;
  int          last_g = -1;
  longint      last_done = 0;

  function automatic int pick();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (m_rd[k] || m_wr[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_read[i]                 = m_rd[i];
      req_write[i]                = m_wr[i];
      req_address[i*AW +: AW]     = m_addr[i];
      req_write_data[i*DW +: DW]  = m_data[i];
    end
  endtask

  task automatic set_req(input int i, input bit r, input bit w);
    m_rd[i]   = r;
    m_wr[i]   = w;
    m_addr[i] = AW'($urandom);
    m_data[i] = $urandom;
    drive();
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_rd[i] = 1'b0;
      m_wr[i] = 1'b0;
    end
    drive();
  endtask

  // Run one arbitration + transaction; ready is given after `delay` strobe cycles.
  task automatic run_txn(input int delay, input bit berr, input logic [DW-1:0] bdata);
    int  g, n, sc, left, exp_sc;
    bit  ill, timed, got, fin;
    logic [DW-1:0] exp_data;
    bit  exp_err;
    g = pick();
    if (g < 0) begin
      chk("nothing_pending", 1, 0);
      return;
    end
    ill   = m_rd[g] && m_wr[g];
    timed = !ill && TO_EN && (delay > TO - 1);
    exp_sc   = ill ? 0 : (timed ? TO : delay + 1);
    exp_err  = ill || timed || berr;
    exp_data = (ill || timed || m_wr[g]) ? '0 : bdata;
    n = 0; sc = 0; left = delay; got = 0; fin = 0;
    while (!fin) begin
      @(negedge clk);
      a_ready = 1'b0;
      a_rdata = $urandom;
      a_error = 1'($urandom);
      n++;
      if (req_done != 0) begin
        got = 1; fin = 1;
      end else begin
        if (a_read || a_write) begin
          if (sc == 0) begin
            chk("bus_addr", a_addr, m_addr[g]);
            chk("bus_wdata", a_wdata, m_data[g]);
            chk("bus_strobe", {a_read, a_write}, {m_rd[g], m_wr[g]});
          end
          sc++;
          if (left == 0) begin
            a_ready = 1'b1;
            a_rdata = bdata;
            a_error = berr;
          end else left--;
        end
        if (n > 1200) fin = 1;
      end
    end
    chk("done_seen", got, 1);
    chk("done_onehot", req_done, N'(1) << g);
    chk("done_error", req_error, exp_err);
    chk("done_rdata", req_read_data, exp_data);
    chk("strobe_cycles", sc, exp_sc);
    chk("strobe_in_done", {a_read, a_write}, 2'b00);
    last_done = cyc;
    last_g    = g;
    m_rd[g]   = 1'b0;
    m_wr[g]   = 1'b0;
    drive();
    ptr = (g + 1) % N;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_done"}, req_done, 0);
    chk({tag, "_rdata"}, req_read_data, 0);
    chk({tag, "_err"}, req_error, 0);
    chk({tag, "_addr"}, a_addr, 0);
    chk({tag, "_wdata"}, a_wdata, 0);
    chk({tag, "_strobes"}, {a_read, a_write}, 2'b00);
  endtask

  initial begin
    longint prev;
    int     order [5];
    bit     seen;
    reset_  = 1'b0;
    a_ready = 1'b0;
    a_rdata = '0;
    a_error = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    clear_model();
    #22;
    chk_outputs_zero("reset");
    @(negedge clk);
    reset_ = 1'b1;

    // Single read from requester 2 with a slow ready.
    set_req(2, 1, 0);
    m_addr[2] = 8'h1A;
    drive();
    run_txn(4, 0, 32'hDEADBEEF);

    // Illegal op: both strobes requested.
    set_req(1, 1, 1);
    run_txn(0, 0, 32'h12345678);

    // Bus error on a write from requester 3; pointer wraps to 0.
    set_req(3, 0, 1);
    run_txn(0, 1, 32'h0);
    chk("ptr_wrap", ptr, 0);
    set_req(2, 1, 0);
    set_req(0, 0, 1);
    run_txn(1, 0, 32'hA5A5A5A5);
    chk("wrap_grant", last_g, 0);
    run_txn(0, 0, 32'h5A5A5A5A);

    // Reset during BUS: strobes drop at once, no completion.
    set_req(1, 1, 0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (a_read) seen = 1;
    end
    chk("pre_reset_strobe", seen, 1);
    #2 reset_ = 1'b0;
    #1 chk_outputs_zero("midreset");
    @(negedge clk);
    clear_model();
    ptr = 0;
    reset_ = 1'b1;
    set_req(1, 0, 1);
    set_req(3, 1, 0);
    set_req(0, 1, 0);
    run_txn(0, 0, 32'hCAFEF00D);
    chk("post_reset_grant", last_g, 0);
    run_txn(0, 0, 32'h1);
    run_txn(0, 0, 32'h2);

    // Round robin: all write, immediate ready.
    for (int i = 0; i < N; i++) set_req(i, 0, 1);
    prev = 0;
    for (int t = 0; t < 5; t++) begin
      run_txn(0, 0, 32'h0);
      order[t] = last_g;
      if (t > 0) chk("rr_spacing", last_done - prev, 3);
      prev = last_done;
      if (t == 3) set_req(0, 0, 1);
    end
    chk("rr_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0], order[4][3:0]},
        20'h01230);

    // Ready withheld: watchdog fires when enabled, otherwise the strobe is simply held.
    set_req(2, 0, 1);
    run_txn(1001, 0, 32'h0);

    // Randomized traffic.
    for (int it = 0; it < 150; it++) begin
      int r;
      for (int i = 0; i < N; i++) begin
        if (!m_rd[i] && !m_wr[i] && i != last_g && $urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 9);
          if (r == 0)     set_req(i, 1, 1);
          else if (r < 5) set_req(i, 1, 0);
          else            set_req(i, 0, 1);
        end
      end
      if (pick() < 0) set_req((last_g + 1) % N, 1, 0);
      run_txn($urandom_range(0, 5), $urandom_range(0, 3) == 0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssm_master_arbiter.md
# ssm_master_arbiter

Shares the single `a2rtap` master interface of the SSM between `NUM_REQ` internal requesters. It grants the interface round-robin, drives one read or write transaction at a time, waits for `ready`, and returns read data and error status to the granted requester. An optional watchdog aborts transactions that receive no `ready`. The block sits directly in front of `ssm_master`, between the SSM sequencing logic and the tap.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_W`, default 8: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT_CYC`, default 256: watchdog limit in cycles (used only with the macro); ≥2.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset_` in 1: asynchronous, active-low reset.
- `req_address` in NUM_REQ*ADDR_W: per-requester address; slice i belongs to requester i.
- `req_write_data` in NUM_REQ*DATA_W: per-requester write data.
- `req_read` in NUM_REQ: read request; held high until done.
- `req_write` in NUM_REQ: write request; held high until done.
- `req_done` out NUM_REQ: one-hot, one-cycle completion pulse.
- `req_read_data` out DATA_W: shared read data; valid while any `req_done` bit is high.
- `req_error` out 1: error flag; valid while any `req_done` bit is high.
- `a2rtap_master_ifc_address` out ADDR_W: transaction address.
- `a2rtap_master_ifc_write_data` out DATA_W: transaction write data.
- `a2rtap_master_ifc_read` out 1: read strobe, held until ready.
- `a2rtap_master_ifc_write` out 1: write strobe, held until ready.
- `a2rtap_master_ifc_read_data` in DATA_W: read data, sampled with ready.
- `a2rtap_master_ifc_ready` in 1: transaction complete.
- `a2rtap_master_ifc_error` in 1: error, sampled with ready.

## Operation
- FSM states are IDLE, BUS and DONE. Reset puts the FSM in IDLE.
- Reset values: every output is 0, and the round-robin pointer is 0, so requester 0 has highest priority first.
- **IDLE**
  - A requester is pending when `req_read|req_write` is high.
  - Pick the first pending requester at or after the pointer, wrapping modulo `NUM_REQ`.
  - Register the grant index, address, write data and op, then go to BUS.
  - If nothing is pending, stay in IDLE.
- **Illegal op:** if the granted requester has read and write both high, go straight to DONE with `req_error`=1 and `req_read_data`=0. No bus strobe is issued.
- **BUS**
  - Assert the matching strobe with the registered address and data.
  - On `ready`=1: capture read data (reads only; writes return 0) and `error`, drop the strobe, and go to DONE.
- **DONE**
  - Pulse `req_done[grant]` for one cycle with the captured data and error.
  - Set the pointer to grant+1 mod `NUM_REQ`, then go to IDLE.
- **Requester rule:** the requester must deassert its request in the cycle after the `req_done` pulse. A request still high in IDLE is a new transaction.
- **Input changes:** request inputs of the granted requester that change during BUS are ignored, because the values are registered at grant time.
- **Reset mid-transaction:** strobes drop immediately, and no `req_done` is issued.

## Timing
- Minimum turnaround is 3 cycles from request to the next arbitration:
  - Cycle 0: IDLE samples the request.
  - Cycle 1: BUS with the strobe high; ready may arrive here.
  - Cycle 2: DONE pulse.
  - Cycle 3: IDLE.
- Strobes are registered. They are never high in IDLE or DONE, and never high on both lines at once.
- Each `ready` cycle adds 1 cycle of latency.
- Fairness: one transaction per grant, so the worst-case wait is (NUM_REQ−1) transactions.

## Configuration
- `SSM_MASTER_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to BUS and increments each BUS cycle without `ready`.
  - When it reaches `TIMEOUT_CYC`−1, drop the strobe, go to DONE, and return `req_error`=1 with data 0.
  - `ready` in the same cycle as the timeout wins, and the transaction completes normally.
- `SSM_MASTER_ARB_TIMEOUT_EN` undefined: the counter is absent and BUS waits for `ready` indefinitely.

## Structure
- Package `ssm_master_arb_pkg` holds:
  - the FSM state typedef (IDLE/BUS/DONE);
  - the op typedef (RD/WR/ILLEGAL);
  - the `NUM_REQ` range limits.
- Sub-module `ssm_rr_arbiter` (combinational pick from pending vector and pointer, output one-hot plus index, valid) keeps the FSM file small.

## Test plan
- Single read: requester 2 reads address 0x1A; ready arrives 4 cycles after the strobe with data 0xDEADBEEF → `req_done`=0b0100 for one cycle, `req_read_data`=0xDEADBEEF, `req_error`=0.
- Round-robin: all 4 requesters write continuously with immediate ready → grant order 0,1,2,3,0; one `req_done` every 3 cycles.
- Illegal op: requester 1 asserts read and write → no strobe; `req_done`=0b0010, `req_error`=1.
- Bus error: requester 3 writes and ready arrives with error=1 → `req_done`=0b1000, `req_error`=1; the pointer advances to 0.
- Timeout (macro on, TIMEOUT_CYC=16): ready is never asserted → strobe high for exactly 16 cycles, then `req_error`=1. With the macro off, the strobe stays high past 1000 cycles.
- Reset: assert `reset_` during BUS → all outputs 0 asynchronously; after release, requester 0 has priority.
